sram_controller: RTL and testbench

Sequences 32-bit data-memory accesses from the MEM stage onto an external 16-bit asynchronous SRAM as two half-word phases. It holds the pipeline via `ready` until the word is written or assembled. `read_data` feeds the `mem` input of the MEM/WB pipeline register, and `~ready` freezes every pipeline register.

---
 rtl/sram_controller_pkg.sv | 33 +++
 rtl/sram_controller.sv | 118 +++++++++++
 tb/tb_sram_controller.sv | 228 ++++++++++++++++++++++
 3 files changed

// File: rtl/sram_controller_pkg.sv
// Shared constants, FSM encoding and request payload for the 16-bit SRAM data-memory controller.
package sram_controller_pkg;

    localparam int unsigned WORD_WIDTH      = 32;
    localparam int unsigned SRAM_ADDR_WIDTH = 18;
    localparam int unsigned SRAM_DATA_WIDTH = 16;
    localparam int unsigned SRAM_IDX_WIDTH  = SRAM_ADDR_WIDTH - 1;
    localparam int unsigned DATA_MEM_BASE   = 1024;

    typedef enum logic [1:0] {
        SRAM_IDLE = 2'd0,
        SRAM_LOW  = 2'd1,
        SRAM_HIGH = 2'd2,
        SRAM_DONE = 2'd3
    } sram_state_t;

    // Request latched in IDLE; the low half-word goes straight to the data register.
    typedef struct packed {
        logic                       is_write;
        logic [SRAM_IDX_WIDTH-1:0]  idx;
        logic [SRAM_DATA_WIDTH-1:0] wdata_hi;
    } sram_req_t;

    function automatic logic [SRAM_IDX_WIDTH-1:0] word_index(
        input logic [WORD_WIDTH-1:0] addr,
        input logic [WORD_WIDTH-1:0] base
    );
        logic [WORD_WIDTH-1:0] w_off;
        w_off = (addr - base) >> 2;
        return SRAM_IDX_WIDTH'(w_off);
    endfunction

endpackage

// File: rtl/sram_controller.sv
// Splits 32-bit MEM-stage loads/stores into two half-word phases on an asynchronous 16-bit SRAM,
// holding the pipeline through ready until the word is written or assembled.
module sram_controller
    import sram_controller_pkg::*;
#(
    parameter int unsigned SRAM_CYCLES   = 2,
    parameter int unsigned DATA_MEM_BASE = 1024
) (
    input  logic                                            clk,
    input  logic                                            rst,
    input  logic                                            rd_en,
    input  logic                                            wr_en,
    input  logic [sram_controller_pkg::WORD_WIDTH-1:0]      address,
    input  logic [sram_controller_pkg::WORD_WIDTH-1:0]      write_data,
    output logic [sram_controller_pkg::WORD_WIDTH-1:0]      read_data,
    output logic                                            ready,
    output logic [sram_controller_pkg::SRAM_ADDR_WIDTH-1:0] sram_addr,
    output logic [sram_controller_pkg::SRAM_DATA_WIDTH-1:0] sram_dq_out,
    output logic                                            sram_dq_oe,
    input  logic [sram_controller_pkg::SRAM_DATA_WIDTH-1:0] sram_dq_in,
    output logic                                            sram_we_n
);

    localparam int unsigned          CNT_W    = $clog2(SRAM_CYCLES);
    localparam logic [CNT_W-1:0]     CNT_LAST = CNT_W'(SRAM_CYCLES - 1);

    sram_state_t                r_state;
    logic [CNT_W-1:0]           r_cnt;
    sram_req_t                  r_req;
    logic [SRAM_DATA_WIDTH-1:0] r_rd_lo;
    logic [WORD_WIDTH-1:0]      r_read_data;
    logic [SRAM_ADDR_WIDTH-1:0] r_sram_addr;
    logic [SRAM_DATA_WIDTH-1:0] r_dq_out;
    logic                       r_dq_oe;
    logic                       r_we_n;

    logic                       w_req;
    logic                       w_is_write;
    logic                       w_phase_end;
    logic [SRAM_IDX_WIDTH-1:0]  w_idx;

    assign w_req       = rd_en | wr_en;
    assign w_is_write  = wr_en & ~rd_en;
    assign w_phase_end = (r_cnt == CNT_LAST);
    assign w_idx       = word_index(address, WORD_WIDTH'(DATA_MEM_BASE));

    // Sequencer: the first cycle of each phase is address setup, the strobe covers the rest.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= SRAM_IDLE;
            r_cnt       <= '0;
            r_req       <= '0;
            r_rd_lo     <= '0;
            r_read_data <= '0;
            r_sram_addr <= '0;
            r_dq_out    <= '0;
            r_dq_oe     <= 1'b0;
            r_we_n      <= 1'b1;
        end else begin
            case (r_state)
                SRAM_IDLE: begin
                    if (w_req) begin
                        r_req       <= '{is_write: w_is_write, idx: w_idx,
                                         wdata_hi: write_data[WORD_WIDTH-1:SRAM_DATA_WIDTH]};
                        r_state     <= SRAM_LOW;
                        r_cnt       <= '0;
                        r_sram_addr <= {w_idx, 1'b0};
                        r_dq_out    <= write_data[SRAM_DATA_WIDTH-1:0];
                        r_dq_oe     <= w_is_write;
                        r_we_n      <= 1'b1;
                    end
                end
                SRAM_LOW: begin
                    if (w_phase_end) begin
                        r_state     <= SRAM_HIGH;
                        r_cnt       <= '0;
                        r_rd_lo     <= sram_dq_in;
                        r_sram_addr <= {r_req.idx, 1'b1};
                        r_dq_out    <= r_req.wdata_hi;
                        r_we_n      <= 1'b1;
                    end else begin
                        r_cnt  <= r_cnt + CNT_W'(1);
                        r_we_n <= ~r_req.is_write;
                    end
                end
                SRAM_HIGH: begin
                    if (w_phase_end) begin
                        r_state <= SRAM_DONE;
                        r_cnt   <= '0;
                        r_we_n  <= 1'b1;
                        r_dq_oe <= 1'b0;
                        if (!r_req.is_write) begin
                            r_read_data <= {sram_dq_in, r_rd_lo};
                        end
                    end else begin
                        r_cnt  <= r_cnt + CNT_W'(1);
                        r_we_n <= ~r_req.is_write;
                    end
                end
                SRAM_DONE: begin
                    r_state <= SRAM_IDLE;
                end
                default: begin
                    r_state <= SRAM_IDLE;
                end
            endcase
        end
    end

    // Pipeline freeze is ~ready, so ready must react to a new request in the same cycle.
    assign ready       = (r_state == SRAM_DONE) | ((r_state == SRAM_IDLE) & ~w_req);
    assign read_data   = r_read_data;
    assign sram_addr   = r_sram_addr;
    assign sram_dq_out = r_dq_out;
    assign sram_dq_oe  = r_dq_oe;
    assign sram_we_n   = r_we_n;

endmodule

// File: tb/tb_sram_controller.sv
// Randomized bench for sram_controller: two instances (2 and 4 cycles per phase), each on a
// behavioural 16-bit SRAM, checked against a word-level memory model.
module tb_sram_controller;

    logic        clk;
    logic        rst;
    logic        rd_en      [2];
    logic        wr_en      [2];
    logic [31:0] address    [2];
    logic [31:0] write_data [2];
    logic [31:0] read_data  [2];
    logic        ready      [2];
    logic [17:0] sram_addr  [2];
    logic [15:0] dq_out     [2];
    logic [15:0] dq_in      [2];
    logic        dq_oe      [2];
    logic        we_n       [2];

    logic [15:0] mem [2][262144];
    logic [31:0] ref_mem [int];
    logic [34:0] sq [$];

    int n_vec = 0;
    int n_err = 0;

    sram_controller #(.SRAM_CYCLES(2), .DATA_MEM_BASE(1024)) u_dut0 (
        .clk(clk), .rst(rst), .rd_en(rd_en[0]), .wr_en(wr_en[0]),
        .address(address[0]), .write_data(write_data[0]), .read_data(read_data[0]),
        .ready(ready[0]), .sram_addr(sram_addr[0]), .sram_dq_out(dq_out[0]),
        .sram_dq_oe(dq_oe[0]), .sram_dq_in(dq_in[0]), .sram_we_n(we_n[0])
    );

    sram_controller #(.SRAM_CYCLES(4), .DATA_MEM_BASE(1024)) u_dut1 (
        .clk(clk), .rst(rst), .rd_en(rd_en[1]), .wr_en(wr_en[1]),
        .address(address[1]), .write_data(write_data[1]), .read_data(read_data[1]),
        .ready(ready[1]), .sram_addr(sram_addr[1]), .sram_dq_out(dq_out[1]),
        .sram_dq_oe(dq_oe[1]), .sram_dq_in(dq_in[1]), .sram_we_n(we_n[1])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Resolved DQ bus: the controller drives when enabled, otherwise the SRAM drives.
    assign dq_in[0] = dq_oe[0] ? dq_out[0] : mem[0][sram_addr[0]];
    assign dq_in[1] = dq_oe[1] ? dq_out[1] : mem[1][sram_addr[1]];

    always @(posedge clk) begin
        for (int u = 0; u < 2; u++) begin
            if (!we_n[u]) mem[u][sram_addr[u]] = dq_out[u];
        end
    end

    always @(negedge clk) begin
        for (int u = 0; u < 2; u++) begin
            if (!we_n[u]) sq.push_back({u[0], sram_addr[u], dq_out[u]});
        end
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [16:0] widx(input logic [31:0] a);
        logic [31:0] t;
        t = (a - 32'd1024) >> 2;
        return t[16:0];
    endfunction

    function automatic int rkey(input int u, input logic [16:0] idx);
        return u * 32'h20000 + int'(idx);
    endfunction

    function automatic logic [31:0] ref_get(input int u, input logic [16:0] idx);
        if (ref_mem.exists(rkey(u, idx))) return ref_mem[rkey(u, idx)];
        return 32'h0;
    endfunction

    task automatic preload(input int u, input logic [31:0] a, input logic [31:0] w);
        logic [16:0] idx;
        idx = widx(a);
        mem[u][{idx, 1'b0}] = w[15:0];
        mem[u][{idx, 1'b1}] = w[31:16];
        ref_mem[rkey(u, idx)] = w;
    endtask

    // Called just after a rising edge; that cycle is cycle 0 of the access.
    task automatic access(input int u, input logic rd, input logic wr,
                          input logic [31:0] a, input logic [31:0] wd);
        int          n;
        int          lat;
        int          lo;
        int          hi;
        int          bad;
        logic [16:0] idx;
        logic        is_wr;
        logic [31:0] exp_rd;
        logic [31:0] prev_rd;
        logic [34:0] e;
        n       = (u == 0) ? 2 : 4;
        idx     = widx(a);
        is_wr   = wr & ~rd;
        exp_rd  = ref_get(u, idx);
        prev_rd = read_data[u];
        sq.delete();
        rd_en[u] = rd; wr_en[u] = wr; address[u] = a; write_data[u] = wd;
        @(negedge clk);
        chk("ready_on_request", 32'(ready[u]), 32'd0);
        lat = 0;
        do begin
            @(negedge clk);
            lat++;
        end while (!ready[u] && lat < 40);
        chk("latency", lat, 2 * n + 1);
        lo = 0; hi = 0; bad = 0;
        foreach (sq[i]) begin
            e = sq[i];
            if (int'(e[34]) != u) continue;
            if (e[33:16] == {idx, 1'b0} && e[15:0] == wd[15:0]) lo++;
            else if (e[33:16] == {idx, 1'b1} && e[15:0] == wd[31:16]) hi++;
            else bad++;
        end
        if (is_wr) begin
            ref_mem[rkey(u, idx)] = wd;
            chk("strobe_low_cycles", lo, n - 1);
            chk("strobe_high_cycles", hi, n - 1);
            chk("strobe_stray", bad, 0);
            chk("read_data_held", read_data[u], prev_rd);
        end else begin
            chk("read_no_strobe", lo + hi + bad, 0);
            chk("read_data", read_data[u], exp_rd);
        end
        @(posedge clk);
        #1;
        rd_en[u] = 1'b0; wr_en[u] = 1'b0;
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1);
    end

    initial begin
        logic [31:0] a;
        logic [31:0] d;
        int          op;
        for (int u = 0; u < 2; u++) begin
            for (int i = 0; i < 262144; i++) mem[u][i] = 16'h0;
            rd_en[u] = 1'b0; wr_en[u] = 1'b0; address[u] = 32'h0; write_data[u] = 32'h0;
        end
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;

        // Reset values and idle behaviour
        @(negedge clk);
        chk("rst_read_data", read_data[0], 32'h0);
        chk("rst_sram_addr", 32'(sram_addr[0]), 32'h0);
        chk("rst_dq_out", 32'(dq_out[0]), 32'h0);
        for (int c = 0; c < 6; c++) begin
            chk("idle_ready", 32'(ready[0]), 32'd1);
            chk("idle_we_n", 32'(we_n[0]), 32'd1);
            chk("idle_oe", 32'(dq_oe[0]), 32'd0);
            @(negedge clk);
        end
        @(posedge clk); #1;

        // Store then load
        access(0, 1'b0, 1'b1, 32'd1028, 32'hDEADBEEF);
        chk("halfword2", 32'(mem[0][2]), 32'h0000BEEF);
        chk("halfword3", 32'(mem[0][3]), 32'h0000DEAD);
        access(0, 1'b1, 1'b0, 32'd1028, 32'h0);

        // Simultaneous read and write: read wins
        preload(0, 32'd1024, 32'hCAFEF00D);
        access(0, 1'b1, 1'b1, 32'd1024, 32'h12345678);

        // Back-to-back loads
        preload(0, 32'd1032, 32'h5A5AA5A5);
        access(0, 1'b1, 1'b0, 32'd1024, 32'h0);
        access(0, 1'b1, 1'b0, 32'd1032, 32'h0);

        // Reset during the HIGH phase of a write
        preload(0, 32'd1040, 32'hAAAA5555);
        sq.delete();
        wr_en[0] = 1'b1; address[0] = 32'd1040; write_data[0] = 32'h11112222;
        repeat (4) @(negedge clk);
        chk("high_setup_addr", 32'(sram_addr[0]), 32'd9);
        chk("high_setup_we_n", 32'(we_n[0]), 32'd1);
        rst = 1'b1; wr_en[0] = 1'b0;
        @(negedge clk);
        chk("after_rst_ready", 32'(ready[0]), 32'd1);
        chk("after_rst_we_n", 32'(we_n[0]), 32'd1);
        chk("after_rst_oe", 32'(dq_oe[0]), 32'd0);
        chk("after_rst_read_data", read_data[0], 32'h0);
        chk("after_rst_strobes", sq.size(), 1);
        rst = 1'b0;
        chk("halfword9_kept", 32'(mem[0][9]), 32'h0000AAAA);
        ref_mem[rkey(0, widx(32'd1040))] = 32'hAAAA2222;
        @(posedge clk); #1;
        access(0, 1'b1, 1'b0, 32'd1040, 32'h0);

        // Randomized traffic against the word-level model
        for (int k = 0; k < 30; k++) begin
            a  = 32'd1024 + 32'($urandom_range(0, 31)) * 32'd4 + 32'($urandom_range(0, 3));
            d  = $urandom;
            op = $urandom_range(0, 2);
            access(0, op != 1, op != 0, a, d);
        end

        // Four cycles per phase
        access(1, 1'b0, 1'b1, 32'd1100, 32'h0BADF00D);
        access(1, 1'b1, 1'b0, 32'd1100, 32'h0);
        for (int k = 0; k < 6; k++) begin
            a  = 32'd1024 + 32'($urandom_range(0, 7)) * 32'd4;
            op = $urandom_range(0, 1);
            access(1, op == 0, op == 1, a, $urandom);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
